adc_uart_formatter: RTL and testbench

- Consumes 16-bit ADC samples (valid strobe) and an error level from the ADS1115 driver.
- Buffers samples in a small FIFO and serialises each one as ASCII hex lines over a byte-wide UART transmitter handshake.
- Sits between the ADC driver and uart_tx, replacing inline formatting logic in top-level modules.
- Counts samples dropped while the UART is backlogged.

---
 rtl/adc_uart_formatter_pkg.sv | 36 +++
 rtl/adc_uart_formatter_fifo.sv | 47 ++++
 rtl/adc_uart_formatter.sv | 118 +++++++++++
 tb/tb_adc_uart_formatter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_uart_formatter_pkg.sv
// Shared constants, FSM encoding and nibble-to-ASCII helper for adc_uart_formatter.
// ADC_FMT_SEQ_EN widens FIFO entries to carry a 16-bit sequence number.
package adc_uart_formatter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_HEX3 = 4'd1,
        ST_HEX2 = 4'd2,
        ST_HEX1 = 4'd3,
        ST_HEX0 = 4'd4,
        ST_CR   = 4'd5,
        ST_LF   = 4'd6,
        ST_ERR  = 4'd7,
        ST_SEQ3 = 4'd8,
        ST_SEQ2 = 4'd9,
        ST_SEQ1 = 4'd10,
        ST_SEQ0 = 4'd11,
        ST_SP   = 4'd12
    } fmt_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_E  = 8'h45;

`ifdef ADC_FMT_SEQ_EN
    localparam int FIFO_W = 32;
`else
    localparam int FIFO_W = 16;
`endif

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/adc_uart_formatter_fifo.sv
// sample_fifo: power-of-two circular buffer with occupancy count.
// A pop frees the slot in the same cycle, so push while full succeeds when popping.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/adc_uart_formatter.sv
// Buffers ADC samples and prints each as an ASCII hex line over a uart_tx handshake.
// Define ADC_FMT_SEQ_EN to prefix every line with a 16-bit push sequence number.
module adc_uart_formatter
    import adc_uart_formatter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   i_data,
    input  logic                          i_valid,
    input  logic                          i_error,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_start,
    input  logic                          i_tx_busy,
    output logic                          o_overflow,
    output logic [DROP_W-1:0]             o_drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    fmt_state_t        state, nxt;
    logic [FIFO_W-1:0] fifo_din, fifo_dout, hold;
    logic [7:0]        tx_byte;
    logic              full, empty, pop, push, err_armed;

    // Error service wins over queued samples, so only pop when no error is pending.
    assign pop  = (state == ST_IDLE) && !empty && !(i_error && err_armed);
    assign push = i_valid && (!full || pop);

`ifdef ADC_FMT_SEQ_EN
    logic [15:0] seq_cnt;
    assign fifo_din = {seq_cnt, i_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    seq_cnt <= '0;
        else if (push) seq_cnt <= seq_cnt + 16'd1;
    end
`else
    assign fifo_din = i_data;
`endif

    sample_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (o_fifo_level)
    );

    always_comb begin
        tx_byte = 8'h00;
        nxt     = ST_IDLE;
        case (state)
`ifdef ADC_FMT_SEQ_EN
            ST_SEQ3: begin tx_byte = hex_to_ascii(hold[31:28]); nxt = ST_SEQ2; end
            ST_SEQ2: begin tx_byte = hex_to_ascii(hold[27:24]); nxt = ST_SEQ1; end
            ST_SEQ1: begin tx_byte = hex_to_ascii(hold[23:20]); nxt = ST_SEQ0; end
            ST_SEQ0: begin tx_byte = hex_to_ascii(hold[19:16]); nxt = ST_SP;   end
            ST_SP:   begin tx_byte = ASCII_SP;                  nxt = ST_HEX3; end
`endif
            ST_HEX3: begin tx_byte = hex_to_ascii(hold[15:12]); nxt = ST_HEX2; end
            ST_HEX2: begin tx_byte = hex_to_ascii(hold[11:8]);  nxt = ST_HEX1; end
            ST_HEX1: begin tx_byte = hex_to_ascii(hold[7:4]);   nxt = ST_HEX0; end
            ST_HEX0: begin tx_byte = hex_to_ascii(hold[3:0]);   nxt = ST_CR;   end
            ST_CR:   begin tx_byte = ASCII_CR;                  nxt = ST_LF;   end
            ST_LF:   begin tx_byte = ASCII_LF;                  nxt = ST_IDLE; end
            ST_ERR:  begin tx_byte = ASCII_E;                   nxt = ST_CR;   end
            default: begin tx_byte = 8'h00;                     nxt = ST_IDLE; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            hold         <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            err_armed    <= 1'b1;
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else begin
            o_tx_start <= 1'b0;
            if (!i_error) err_armed <= 1'b1;
            if (i_valid && !push) begin
                o_overflow <= 1'b1;
                if (o_drop_count != '1) o_drop_count <= o_drop_count + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (i_error && err_armed) begin
                        state     <= ST_ERR;
                        err_armed <= 1'b0;
                    end else if (!empty) begin
                        hold <= fifo_dout;
`ifdef ADC_FMT_SEQ_EN
                        state <= ST_SEQ3;
`else
                        state <= ST_HEX3;
`endif
                    end
                end
                default: begin
                    // Waiting for o_tx_start to drop guarantees an idle cycle between starts.
                    if (!i_tx_busy && !o_tx_start) begin
                        o_tx_data  <= tx_byte;
                        o_tx_start <= 1'b1;
                        state      <= nxt;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_uart_formatter.sv
// Directed and randomized checks of adc_uart_formatter against a line-text model.
module tb_adc_uart_formatter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_error = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_busy;
    logic        o_overflow;
    logic [7:0]  o_drop_count;
    logic [2:0]  o_fifo_level;

    int checks = 0;
    int errors = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int   seq_m = 0;
    int   bcnt = 0;
    logic prev_start = 1'b0;

    always #5 clk = ~clk;

    adc_uart_formatter #(.FIFO_DEPTH(4), .DROP_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_error      (i_error),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_busy    (i_tx_busy),
        .o_overflow   (o_overflow),
        .o_drop_count (o_drop_count),
        .o_fifo_level (o_fifo_level)
    );

    // uart_tx stand-in: busy from the cycle after start for 10 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bcnt <= 0;
        else if (o_tx_start) bcnt <= 10;
        else if (bcnt != 0)  bcnt <= bcnt - 1;
    end
    assign i_tx_busy = (bcnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_tx_start) begin
            chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
            got.push_back(o_tx_data);
        end
        prev_start <= o_tx_start;
    end

    function automatic logic [7:0] hexc(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    task automatic add_hex4(input int v);
        for (int k = 3; k >= 0; k--) exp_q.push_back(hexc((v >> (4 * k)) & 15));
    endtask

    task automatic add_line(input logic [15:0] d);
`ifdef ADC_FMT_SEQ_EN
        add_hex4(seq_m);
        exp_q.push_back(8'h20);
`endif
        seq_m = (seq_m + 1) % 65536;
        add_hex4(int'(d));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic add_err();
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got.size() < n && t < 3000) begin @(negedge clk); t++; end
        if (t >= 3000) chk("wait_bytes_timeout", got.size(), n);
    endtask

    task automatic drain_compare(input string tag);
        int t = 0;
        while ((got.size() < exp_q.size() || o_fifo_level != 0) && t < 8000) begin
            @(negedge clk); t++;
        end
        repeat (30) @(negedge clk);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        exp_q.delete();
        seq_m = 0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int n_pre;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_drop", o_drop_count, 0);
        chk("rst_level", o_fifo_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sample with latency measurement from the sampling edge
        i_data = 16'h1A2F; i_valid = 1'b1; add_line(16'h1A2F);
        @(negedge clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_tx_start && lat < 50) begin @(negedge clk); lat++; end
        chk("latency", lat, 2);
        drain_compare("single");

        // Backlog: with line 0000 in flight, 0001..0004 fill the FIFO and 0005/0006 drop
        i_data = 16'h0000; i_valid = 1'b1; add_line(16'h0000);
        @(negedge clk); i_valid = 1'b0;
        wait_got(1);
        for (int d = 1; d <= 6; d++) begin
            i_data = 16'(d); i_valid = 1'b1;
            if (d <= 4) add_line(16'(d));
            @(negedge clk);
        end
        i_valid = 1'b0;
        chk("backlog_drop", o_drop_count, 2);
        chk("backlog_overflow", o_overflow, 1);
        chk("backlog_level", o_fifo_level, 4);
        drain_compare("backlog");

        // Full boundary: push on the very cycle IDLE pops a full FIFO
        i_data = 16'h0A00; i_valid = 1'b1; add_line(16'h0A00);
        @(negedge clk); i_valid = 1'b0;
        wait_got(1);
        for (int d = 1; d <= 4; d++) begin
            i_data = 16'h0A00 + 16'(d); i_valid = 1'b1; add_line(16'h0A00 + 16'(d));
            @(negedge clk);
        end
        i_valid = 1'b0;
        chk("full_level", o_fifo_level, 4);
        lat = 0;
        while (!(o_tx_start && o_tx_data == 8'h0A && o_fifo_level == 3'd4) && lat < 3000) begin
            @(negedge clk); lat++;
        end
        chk("full_lf_seen", {31'd0, lat < 3000}, 1);
        i_data = 16'h0A05; i_valid = 1'b1; add_line(16'h0A05);
        @(negedge clk); i_valid = 1'b0;
        chk("full_pushpop_level", o_fifo_level, 4);
        chk("full_pushpop_drop", o_drop_count, 2);
        drain_compare("full");

        // Error priority over a queued sample; one E line per assertion
        i_error = 1'b1; i_data = 16'h7FFF; i_valid = 1'b1;
        add_err(); add_line(16'h7FFF);
        @(negedge clk); i_valid = 1'b0;
        repeat (499) @(negedge clk);
        i_error = 1'b0;
        @(negedge clk);
        i_error = 1'b1; add_err();
        repeat (100) @(negedge clk);
        i_error = 1'b0;
        drain_compare("error");

        // Randomized bursts that fit the FIFO, random gaps
        for (int it = 0; it < 8; it++) begin
            int blen = int'($urandom_range(1, 4));
            for (int b = 0; b < blen; b++) begin
                logic [15:0] r = 16'($urandom);
                i_data = r; i_valid = 1'b1; add_line(r);
                @(negedge clk); i_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            drain_compare($sformatf("rand%0d", it));
        end

        // Reset mid-line during HEX1
`ifdef ADC_FMT_SEQ_EN
        n_pre = 7;
`else
        n_pre = 2;
`endif
        i_data = 16'h1234; i_valid = 1'b1; @(negedge clk);
        i_data = 16'h5678; @(negedge clk);
        i_valid = 1'b0;
        wait_got(n_pre);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_start", o_tx_start, 0);
        chk("midrst_level", o_fifo_level, 0);
        chk("midrst_data", o_tx_data, 0);
        chk("midrst_overflow", o_overflow, 0);
        chk("midrst_drop", o_drop_count, 0);
        do_reset();
        i_data = 16'hBEEF; i_valid = 1'b1; add_line(16'hBEEF);
        @(negedge clk); i_valid = 1'b0;
        drain_compare("beef");

        // Fresh reset then three samples (sequence numbers 0..2 when enabled)
        do_reset();
        for (int d = 1; d <= 3; d++) begin
            i_data = 16'(d * 16); i_valid = 1'b1; add_line(16'(d * 16));
            @(negedge clk);
        end
        i_valid = 1'b0;
        drain_compare("seq3");
        chk("seq3_drop", o_drop_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
